// File: rtl/apx_err_monitor_pkg.sv
// Shared types and width helpers for the approximate-adder error monitor.
package apx_err_pkg;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        RPT   = 2'd2
    } state_e;

    function automatic int ed_width(input int width);
        return width + 1;
    endfunction

    function automatic int sum_width(input int width, input int win_log2);
        return width + 1 + win_log2;
    endfunction

endpackage

// File: rtl/apx_err_monitor_err_dist.sv
// Combinational exact sum and error distance for one operand pair.
// The signed diff output exists only when APX_ERR_BIAS_EN is defined.
module err_dist #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [WIDTH:0]        sum_apx,
    output logic [WIDTH:0]        exact,
    output logic [WIDTH:0]        ed
`ifdef APX_ERR_BIAS_EN
    ,
    output logic signed [WIDTH+1:0] diff
`endif
);

    assign exact = {1'b0, a} + {1'b0, b};
    assign ed    = (exact >= sum_apx) ? (exact - sum_apx) : (sum_apx - exact);

`ifdef APX_ERR_BIAS_EN
    assign diff = $signed({1'b0, sum_apx}) - $signed({1'b0, exact});
`endif

endmodule

// File: rtl/apx_err_monitor.sv
// Windowed error statistics for a WIDTH-bit approximate adder, reported over valid/ready.
// Optional signed bias accumulator enabled by APX_ERR_BIAS_EN.
module apx_err_monitor
    import apx_err_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int WIN_LOG2 = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_a,
    input  logic [WIDTH-1:0]          in_b,
    input  logic [WIDTH:0]            in_sum_apx,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIN_LOG2:0]         err_cnt,
    output logic [WIDTH+WIN_LOG2:0]   ed_sum,
    output logic [WIDTH:0]            ed_max
`ifdef APX_ERR_BIAS_EN
    ,
    output logic signed [WIDTH+WIN_LOG2+1:0] ed_bias
`endif
);

    localparam int ED_W  = ed_width(WIDTH);
    localparam int SUM_W = sum_width(WIDTH, WIN_LOG2);

    state_e              state_q;
    logic [WIN_LOG2-1:0] cnt_q;
    logic                drain_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic [ED_W-1:0]     dist_exact;
    logic [ED_W-1:0]     dist_ed;

    logic                v1_q;
    logic [ED_W-1:0]     ed_q;
    logic                nz_q;

    logic [WIN_LOG2:0]   err_cnt_q, err_cnt_d;
    logic [SUM_W-1:0]    ed_sum_q,  ed_sum_d;
    logic [ED_W-1:0]     ed_max_q,  ed_max_d;

    logic accept;
    logic clear;

    assign accept = in_valid & in_ready_q;
    assign clear  = out_valid_q & out_ready;

`ifdef APX_ERR_BIAS_EN
    logic signed [ED_W:0]  dist_diff;
    logic signed [ED_W:0]  diff_q;
    logic signed [SUM_W:0] bias_q, bias_d;
`endif

    err_dist #(
        .WIDTH (WIDTH)
    ) u_err_dist (
        .a       (in_a),
        .b       (in_b),
        .sum_apx (in_sum_apx),
        .exact   (dist_exact),
        .ed      (dist_ed)
`ifdef APX_ERR_BIAS_EN
        ,
        .diff    (dist_diff)
`endif
    );

    // DRAIN spends two cycles so both pipeline stages retire before reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC;
            cnt_q       <= '0;
            drain_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == '1) begin
                            state_q    <= DRAIN;
                            in_ready_q <= 1'b0;
                            drain_q    <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        state_q     <= RPT;
                        out_valid_q <= 1'b1;
                    end
                end
                RPT: begin
                    if (out_ready) begin
                        state_q     <= ACC;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ACC;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            ed_q <= '0;
            nz_q <= 1'b0;
`ifdef APX_ERR_BIAS_EN
            diff_q <= '0;
`endif
        end else begin
            v1_q <= accept;
            if (accept) begin
                ed_q <= dist_ed;
                nz_q <= (dist_exact != in_sum_apx);
`ifdef APX_ERR_BIAS_EN
                diff_q <= dist_diff;
`endif
            end
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        ed_sum_d  = ed_sum_q;
        ed_max_d  = ed_max_q;
        if (v1_q) begin
            err_cnt_d = err_cnt_q + {{WIN_LOG2{1'b0}}, nz_q};
            ed_sum_d  = ed_sum_q + {{WIN_LOG2{1'b0}}, ed_q};
            ed_max_d  = (ed_q > ed_max_q) ? ed_q : ed_max_q;
        end
    end

`ifdef APX_ERR_BIAS_EN
    always_comb begin
        bias_d = bias_q;
        if (v1_q) begin
            bias_d = bias_q + {{WIN_LOG2{diff_q[ED_W]}}, diff_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bias_q <= '0;
        end else begin
            bias_q <= bias_d;
        end
    end

    assign ed_bias = bias_q;
`endif

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_cnt_q <= '0;
            ed_sum_q  <= '0;
            ed_max_q  <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            ed_sum_q  <= ed_sum_d;
            ed_max_q  <= ed_max_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign err_cnt   = err_cnt_q;
    assign ed_sum    = ed_sum_q;
    assign ed_max    = ed_max_q;

endmodule

// File: tb/tb_apx_err_monitor.sv
// Randomized bench for apx_err_monitor against a per-window arithmetic reference model.
// Define APX_ERR_BIAS_EN to also exercise the ed_bias output.
module tb_apx_err_monitor;

    localparam int W = 16;
    localparam int L = 8;
    localparam int WIN = 1 << L;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic [W:0]      in_sum_apx;
    logic            out_valid;
    logic            out_ready;
    logic [L:0]      err_cnt;
    logic [W+L:0]    ed_sum;
    logic [W:0]      ed_max;
`ifdef APX_ERR_BIAS_EN
    logic signed [W+L+1:0] ed_bias;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    longint exp_cnt, exp_sum, exp_max, exp_bias;

    apx_err_monitor #(
        .WIDTH    (W),
        .WIN_LOG2 (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sum_apx (in_sum_apx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_cnt    (err_cnt),
        .ed_sum     (ed_sum),
        .ed_max     (ed_max)
`ifdef APX_ERR_BIAS_EN
        ,
        .ed_bias    (ed_bias)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_err_cnt"}, longint'(err_cnt), exp_cnt);
        check({tag, "_ed_sum"},  longint'(ed_sum),  exp_sum);
        check({tag, "_ed_max"},  longint'(ed_max),  exp_max);
`ifdef APX_ERR_BIAS_EN
        check({tag, "_ed_bias"}, longint'(ed_bias), exp_bias);
`endif
    endtask

    // mode 0: constant exact, 1: one carry-window miss, 2: max error,
    // 3: random mix, 4: bias pattern (+3 then -1)
    task automatic gen(input int mode, input int idx,
                       output logic [W-1:0] a, output logic [W-1:0] b, output logic [W:0] s);
        int ex;
        a = W'($urandom);
        b = W'($urandom);
        case (mode)
            0: begin a = 16'h1234; b = 16'h0001; end
            1: if (idx == 37) begin a = 16'h03FF; b = 16'h0001; end
            2: begin a = 16'hFFFF; b = 16'h0001; end
            4: begin a = {1'b0, a[W-2:0]}; b = {1'b0, b[W-2:0]} + 16'd1; end
            default: ;
        endcase
        ex = int'(a) + int'(b);
        case (mode)
            0: s = 17'h01235;
            1: s = (idx == 37) ? 17'h00200 : (W+1)'(ex);
            2: s = 17'h00000;
            4: s = (idx < WIN / 2) ? (W+1)'(ex + 3) : (W+1)'(ex - 1);
            default: begin
                case ($urandom_range(3))
                    0:       s = (W+1)'(ex);
                    1:       s = (W+1)'(ex ^ (1 << $urandom_range(W)));
                    2:       s = (W+1)'($urandom);
                    default: s = (W+1)'(ex & ~int'($urandom_range(255)));
                endcase
            end
        endcase
    endtask

    task automatic model_accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] s);
        longint d, ed;
        d  = longint'(s) - (longint'(a) + longint'(b));
        ed = (d < 0) ? -d : d;
        if (ed != 0) exp_cnt++;
        exp_sum  += ed;
        if (ed > exp_max) exp_max = ed;
        exp_bias += d;
    endtask

    task automatic model_clear();
        exp_cnt = 0; exp_sum = 0; exp_max = 0; exp_bias = 0;
    endtask

    task automatic run_window(input int mode, input int hold, input int gap_pct);
        int n, cyc, lat;
        logic [W-1:0] a, b;
        logic [W:0]   s;
        logic         v;
        n = 0;
        cyc = 0;
        model_clear();
        while (n < WIN) begin
            @(negedge clk);
            cyc++;
            check("busy_out_valid", longint'(out_valid), 0);
            v = ($urandom_range(99) >= gap_pct);
            gen(mode, n, a, b, s);
            in_valid   = v;
            in_a       = a;
            in_b       = b;
            in_sum_apx = s;
            out_ready  = $urandom_range(1);
            if (v && in_ready) begin
                model_accept(a, b, s);
                n++;
            end
            if (cyc > 20000) begin
                check("accept_timeout", n, WIN);
                break;
            end
        end
        out_ready = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            in_valid   = 1'b1;
            in_a       = W'($urandom);
            in_b       = W'($urandom);
            in_sum_apx = (W+1)'($urandom);
        end while (!out_valid && lat < 20);
        check("latency", lat, 3);
        check("rpt_out_valid", longint'(out_valid), 1);
        check("rpt_in_ready", longint'(in_ready), 0);
        check_stats("rpt");
        repeat (hold) begin
            @(negedge clk);
            check("hold_out_valid", longint'(out_valid), 1);
            check("hold_in_ready", longint'(in_ready), 0);
            check_stats("hold");
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_out_valid", longint'(out_valid), 0);
        check("post_in_ready", longint'(in_ready), 1);
        model_clear();
        check_stats("post_clear");
    endtask

    task automatic reset_mid_window();
        int n;
        logic [W-1:0] a, b;
        logic [W:0]   s;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            gen(2, n, a, b, s);
            in_valid = 1'b1; in_a = a; in_b = b; in_sum_apx = s;
            if (in_ready) n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("partial_ed_sum", longint'(ed_sum), 99 * 65536);
        check("partial_err_cnt", longint'(err_cnt), 99);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check_stats("rst");
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_sum_apx = '0;
        out_ready  = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", longint'(in_ready), 0);
        check("reset_out_valid", longint'(out_valid), 0);
        check_stats("reset");
        rst = 1'b0;

        run_window(0, 0, 0);
        run_window(1, 2, 0);
        run_window(2, 0, 0);
        run_window(3, 10, 0);
        for (int i = 0; i < 3; i++) begin
            run_window(3, $urandom_range(5), 30);
        end
        reset_mid_window();
        run_window(3, 1, 30);
`ifdef APX_ERR_BIAS_EN
        run_window(4, 3, 20);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
